// File: rtl/graph_loader.sv
// Graph edge loader: builds an N x N adjacency matrix from a stream of edge beats, then
// computes per-node weights 1/outdeg by restoring division. Option macro: GRAPH_LOADER_DANGLING_EN.
module graph_loader #(
    parameter int N     = 4,
    parameter int WIDTH = 16,
    localparam int IDW  = $clog2(N)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clear,
    input  logic               edge_valid,
    output logic               edge_ready,
    input  logic [IDW-1:0]     edge_src,
    input  logic [IDW-1:0]     edge_dst,
    input  logic               edge_last,
    output logic [N*N-1:0]     adj,
    output logic [N*WIDTH-1:0] nodeWeight,
    output logic               done
);
    localparam int SW = $clog2(WIDTH + 1);
    localparam int RW = IDW + 2;
    localparam logic [SW-1:0]    LAST_STEP = SW'(WIDTH);
    localparam logic [IDW-1:0]   LAST_NODE = IDW'(N - 1);
    localparam logic [WIDTH-1:0] ONE_W     = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] DANG_W    = ONE_W << (WIDTH - IDW);

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_r, state_s;
    logic               ready_r, done_r;
    logic [N*N-1:0]     adj_r, adj_s, fill_s;
    logic [N*WIDTH-1:0] weight_r;
    logic [IDW:0]       outdeg_r [N];
    logic [IDW:0]       outdeg_s [N];
    logic [IDW-1:0]     node_r;
    logic [SW-1:0]      step_r;
    logic [RW-1:0]      rem_r, rem_s;
    logic [WIDTH:0]     quo_r, quo_s;
    logic [IDW:0]       d_s;
    logic [RW:0]        trial_s, diff_s;
    logic               ge_s;
    logic [WIDTH-1:0]   weight_s;
    logic [2*IDW-1:0]   idx_s;
    logic               xfer_s, last_s, calc_end_s;

    assign edge_ready = ready_r;
    assign done       = done_r;
    assign adj        = adj_r;
    assign nodeWeight = weight_r;

    // ready is only ever high in LOAD, so a transfer implies LOAD
    assign xfer_s     = edge_valid && ready_r;
    assign last_s     = xfer_s && edge_last;
    assign calc_end_s = (state_r == CALC) && (node_r == LAST_NODE) && (step_r == LAST_STEP);
    assign idx_s      = {edge_dst, edge_src};

    // Next-state logic; clear overrides everything else
    always_comb begin
        state_s = state_r;
        case (state_r)
            LOAD: begin
                if (clear)       state_s = LOAD;
                else if (last_s) state_s = CALC;
                else             state_s = LOAD;
            end
            CALC: begin
                if (clear)           state_s = LOAD;
                else if (calc_end_s) state_s = DONE;
                else                 state_s = CALC;
            end
            DONE: begin
                if (clear) state_s = LOAD;
                else       state_s = DONE;
            end
            default: state_s = LOAD;
        endcase
    end

    // State register with registered ready/done decoded from the next state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= LOAD;
            ready_r <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            ready_r <= (state_s == LOAD);
            done_r  <= (state_s == DONE);
        end
    end

    // Edge insertion: only a previously clear bit bumps the source out-degree
    always_comb begin
        adj_s    = adj_r;
        outdeg_s = outdeg_r;
        if (xfer_s && !adj_r[idx_s]) begin
            adj_s[idx_s]       = 1'b1;
            outdeg_s[edge_src] = outdeg_r[edge_src] + {{IDW{1'b0}}, 1'b1};
        end else begin
            adj_s = adj_r;
        end
        fill_s = adj_s;
`ifdef GRAPH_LOADER_DANGLING_EN
        for (int j = 0; j < N; j++) begin
            for (int i = 0; i < N; i++) begin
                fill_s[i*N+j] = adj_s[i*N+j] | (outdeg_s[j] == {(IDW+1){1'b0}});
            end
        end
`endif
    end

    // One restoring step; the dividend 2^WIDTH contributes a 1 only on the first step
    always_comb begin
        d_s     = outdeg_r[node_r];
        trial_s = {rem_r, (step_r == {SW{1'b0}})};
        diff_s  = trial_s - {2'b00, d_s};
        ge_s    = (trial_s >= {2'b00, d_s});
        if (ge_s) rem_s = diff_s[RW-1:0];
        else      rem_s = trial_s[RW-1:0];
        quo_s = {quo_r[WIDTH-1:0], ge_s};
        if (d_s == {(IDW+1){1'b0}}) begin
`ifdef GRAPH_LOADER_DANGLING_EN
            weight_s = DANG_W;
`else
            weight_s = {WIDTH{1'b0}};
`endif
        end else if (quo_s[WIDTH]) begin
            weight_s = {WIDTH{1'b1}};
        end else begin
            weight_s = quo_s[WIDTH-1:0];
        end
    end

    // Datapath: adjacency build in LOAD, per-node division in CALC, hold in DONE
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            adj_r    <= {(N*N){1'b0}};
            weight_r <= {(N*WIDTH){1'b0}};
            for (int k = 0; k < N; k++) outdeg_r[k] <= {(IDW+1){1'b0}};
            node_r   <= {IDW{1'b0}};
            step_r   <= {SW{1'b0}};
            rem_r    <= {RW{1'b0}};
            quo_r    <= {(WIDTH+1){1'b0}};
        end else if (clear) begin
            adj_r    <= {(N*N){1'b0}};
            weight_r <= {(N*WIDTH){1'b0}};
            for (int k = 0; k < N; k++) outdeg_r[k] <= {(IDW+1){1'b0}};
            node_r   <= {IDW{1'b0}};
            step_r   <= {SW{1'b0}};
            rem_r    <= {RW{1'b0}};
            quo_r    <= {(WIDTH+1){1'b0}};
        end else begin
            case (state_r)
                LOAD: begin
                    if (last_s) adj_r <= fill_s;
                    else        adj_r <= adj_s;
                    outdeg_r <= outdeg_s;
                end
                CALC: begin
                    if (step_r == LAST_STEP) begin
                        weight_r[node_r*WIDTH +: WIDTH] <= weight_s;
                        node_r <= node_r + {{(IDW-1){1'b0}}, 1'b1};
                        step_r <= {SW{1'b0}};
                        rem_r  <= {RW{1'b0}};
                        quo_r  <= {(WIDTH+1){1'b0}};
                    end else begin
                        step_r <= step_r + {{(SW-1){1'b0}}, 1'b1};
                        rem_r  <= rem_s;
                        quo_r  <= quo_s;
                    end
                end
                default: begin
                    adj_r <= adj_r;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_graph_loader.sv
// Self-checking bench for graph_loader: directed and random graphs against a set-based model.
module tb_graph_loader;
    localparam int N = 4;
    localparam int W = 16;
    localparam int IDW = 2;
`ifdef GRAPH_LOADER_DANGLING_EN
    localparam bit DANG = 1'b1;
`else
    localparam bit DANG = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset, clear, edge_valid, edge_ready, edge_last, done;
    logic [IDW-1:0] edge_src, edge_dst;
    logic [N*N-1:0] adj;
    logic [N*W-1:0] nodeWeight;

    int n_cmp = 0;
    int n_fail = 0;
    bit m_adj [N*N];
    int src_q[$];
    int dst_q[$];

    graph_loader #(.N(N), .WIDTH(W)) dut (
        .clk(clk), .reset(reset), .clear(clear),
        .edge_valid(edge_valid), .edge_ready(edge_ready),
        .edge_src(edge_src), .edge_dst(edge_dst), .edge_last(edge_last),
        .adj(adj), .nodeWeight(nodeWeight), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int deg_of(input int j);
        int c = 0;
        for (int i = 0; i < N; i++) c += int'(m_adj[i*N+j]);
        return c;
    endfunction

    function automatic logic [N*N-1:0] exp_adj();
        logic [N*N-1:0] r = '0;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                r[i*N+j] = m_adj[i*N+j] || (DANG && deg_of(j) == 0);
        return r;
    endfunction

    function automatic logic [N*W-1:0] exp_w();
        logic [N*W-1:0] r = '0;
        longint full = longint'(1) << W;
        longint w;
        for (int j = 0; j < N; j++) begin
            int d = deg_of(j);
            if (d == 0)             w = DANG ? full / N : 0;
            else if (full / d > full - 1) w = full - 1;
            else                    w = full / d;
            r[j*W +: W] = w[W-1:0];
        end
        return r;
    endfunction

    task automatic model_clear();
        for (int k = 0; k < N*N; k++) m_adj[k] = 1'b0;
    endtask

    task automatic send(input int s, input int d, input bit last);
        int k = 0;
        while (!edge_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (!edge_ready) chk("ready_timeout", {127'd0, edge_ready}, 128'd1);
        edge_valid = 1'b1;
        edge_src   = IDW'(s);
        edge_dst   = IDW'(d);
        edge_last  = last;
        @(negedge clk);
        edge_valid = 1'b0;
        edge_last  = 1'b0;
        m_adj[d*N+s] = 1'b1;
    endtask

    task automatic load_edges();
        model_clear();
        for (int k = 0; k < src_q.size(); k++)
            send(src_q[k], dst_q[k], k == src_q.size() - 1);
    endtask

    // Waits for done with edge_valid held high; checks latency, ready, frozen adj, weights
    task automatic wait_done(input string tag);
        int cnt = 0;
        int bad = 0;
        logic [N*N-1:0] ea = exp_adj();
        edge_valid = 1'b1;
        edge_src   = IDW'($urandom_range(0, N-1));
        edge_dst   = IDW'($urandom_range(0, N-1));
        while (!done && cnt < 200) begin
            if (edge_ready !== 1'b0 || adj !== ea) bad++;
            @(negedge clk);
            cnt++;
        end
        chk({tag, "_calc_cycles"}, 128'(cnt), 128'(N*(W+1)));
        chk({tag, "_weights"}, 128'(nodeWeight), 128'(exp_w()));
        for (int k = 0; k < 5; k++) begin
            if (edge_ready !== 1'b0 || adj !== ea || done !== 1'b1) bad++;
            @(negedge clk);
        end
        chk({tag, "_hold_bad_cycles"}, 128'(bad), 128'd0);
        edge_valid = 1'b0;
    endtask

    task automatic load_graph(input string tag);
        load_edges();
        chk({tag, "_adj"}, 128'(adj), 128'(exp_adj()));
        wait_done(tag);
    endtask

    task automatic pulse_clear(input string tag);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        model_clear();
        chk({tag, "_adj"}, 128'(adj), 128'd0);
        chk({tag, "_done"}, 128'(done), 128'd0);
        chk({tag, "_ready"}, 128'(edge_ready), 128'd1);
        chk({tag, "_weights"}, 128'(nodeWeight), 128'd0);
    endtask

    task automatic set_graph_a();
        src_q = '{2, 3, 0, 0, 1, 3, 0, 1};
        dst_q = '{0, 0, 1, 2, 2, 2, 3, 3};
    endtask

    initial begin
        int dcount;
        reset = 1'b1; clear = 1'b0; edge_valid = 1'b0; edge_last = 1'b0;
        edge_src = '0; edge_dst = '0;
        model_clear();
        repeat (3) @(negedge clk);
        chk("rst_ready", 128'(edge_ready), 128'd0);
        chk("rst_done", 128'(done), 128'd0);
        chk("rst_adj", 128'(adj), 128'd0);
        chk("rst_weights", 128'(nodeWeight), 128'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", 128'(edge_ready), 128'd1);

        // reference graph
        set_graph_a();
        load_graph("graph_a");
        if (!DANG) chk("graph_a_const_w", 128'(nodeWeight), 128'h8000_FFFF_8000_5555);
        pulse_clear("clear_a");

        // duplicate edges ignored
        src_q = '{2, 2, 3, 0, 0, 2, 1, 3, 0, 1};
        dst_q = '{0, 0, 0, 1, 2, 0, 2, 2, 3, 3};
        load_graph("dup");
        chk("dup_w2", 128'(nodeWeight[2*W +: W]), 128'hFFFF);
        pulse_clear("clear_dup");

        // single edge: dangling handling differs per build
        src_q = '{0};
        dst_q = '{1};
        load_graph("single");
        pulse_clear("clear_single");

        // clear wins over a simultaneous edge transfer
        edge_valid = 1'b1; edge_src = 2'd1; edge_dst = 2'd2; edge_last = 1'b0;
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0; edge_valid = 1'b0;
        chk("clear_vs_edge_adj", 128'(adj), 128'd0);
        chk("clear_vs_edge_ready", 128'(edge_ready), 128'd1);

        // random graphs, duplicates and self-loops arise naturally
        for (int g = 0; g < 6; g++) begin
            int n = $urandom_range(1, 10);
            src_q.delete();
            dst_q.delete();
            for (int k = 0; k < n; k++) begin
                src_q.push_back($urandom_range(0, N-1));
                dst_q.push_back($urandom_range(0, N-1));
            end
            load_graph($sformatf("rand%0d", g));
            pulse_clear($sformatf("clear_rand%0d", g));
        end

        // reset 10 cycles into CALC abandons the computation
        set_graph_a();
        load_edges();
        repeat (10) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("midcalc_rst_adj", 128'(adj), 128'd0);
        chk("midcalc_rst_weights", 128'(nodeWeight), 128'd0);
        chk("midcalc_rst_done", 128'(done), 128'd0);
        chk("midcalc_rst_ready", 128'(edge_ready), 128'd0);
        dcount = 0;
        repeat (3) begin
            @(negedge clk);
            if (done !== 1'b0) dcount++;
        end
        reset = 1'b0;
        model_clear();
        repeat (80) begin
            @(negedge clk);
            if (done !== 1'b0) dcount++;
        end
        chk("midcalc_done_never", 128'(dcount), 128'd0);
        chk("midcalc_ready_after", 128'(edge_ready), 128'd1);
        set_graph_a();
        load_graph("reload_a");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
